// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Operand source selected for an Execute-stage ALU input.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file value read in Decode
    FWD_WB  = 2'b01,  // Writeback result
    FWD_MEM = 2'b10   // Memory-stage ALU result
  } fwd_sel_t;

  // Mul/div sequencing state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // x0 is hardwired to zero, so it never creates a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one Execute source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: rs_e (Execute source), rd_m/rd_w + reg_write_m/reg_write_w
//        (later-stage destinations and write enables), fwd_sel (chosen source).
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_sel
);

  // Memory is checked first: it holds the younger producer, so its value
  // is the architecturally correct one when both stages match.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rs_e == rd_m) && (rs_e != REG_ZERO)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rs_e == rd_w) && (rs_e != REG_ZERO)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: forwarding selects, load-use stall, branch flush, mul/div freeze.
// Latency: controls are combinational; a mul/div holds Execute MD_LATENCY+2 cycles.
// Backpressure: StallF/D/E freeze upstream stages; FlushM drains bubbles downstream.
// Ports: clk, reset (sync, active-high); Decode/Execute/Memory/Writeback register
//        ids and write enables; ResultSrcE0, PCSrcE, MulDivE hazard inputs;
//        ForwardAE/BE, StallF/D/E, FlushD/E/M, MdStart, MdBusy outputs.
// Build option PIPE_CTRL_STATS_EN adds saturating StallCycles/FlushCount counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MulDivE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdStart,
  output logic        MdBusy
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam int CNT_W = $clog2(MD_LATENCY);

  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  md_state_t         state;
  md_state_t         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              lw_stall;
  logic              md_stall;

  // ---------------- forwarding ----------------
  fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // ---------------- load-use hazard ----------------
  assign lw_stall = ResultSrcE0 && (RdE != REG_ZERO) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // ---------------- mul/div FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------- mul/div FSM: next state ----------------
  // BUSY spans MD_LATENCY cycles (counter MD_LATENCY-1 down to 0). DONE
  // always returns to IDLE so the released instruction cannot retrigger.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (MulDivE) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- mul/div FSM: outputs ----------------
  // Start is Mealy so the unit launches in the same cycle the op reaches Execute.
  always_comb begin
    MdStart  = (state == IDLE) && MulDivE;
    MdBusy   = (state == BUSY);
    md_stall = MdStart || MdBusy;
  end

  // ---------------- stage controls ----------------
  // A mul/div freeze outranks load-use and branch handling: the held
  // Execute op is the mul/div itself, and the load-use check is simply
  // re-evaluated once the freeze lifts in DONE.
  always_comb begin
    StallF = lw_stall || md_stall;
    StallD = lw_stall || md_stall;
    StallE = md_stall;
    FlushE = (lw_stall || PCSrcE) && !md_stall;
    FlushD = PCSrcE && !md_stall;
    FlushM = md_stall;
  end

  // ---------------- optional statistics ----------------
`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != '1)) StallCycles <= StallCycles + 32'd1;
      if (FlushE && (FlushCount  != '1)) FlushCount  <= FlushCount  + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a queued scoreboard.
// Latency: one expectation per clock cycle, compared mid-cycle.
// Backpressure: none; the monitor pops whenever an expectation is queued.
module tb_pipe_ctrl;

  localparam int MD_LATENCY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pcsrc, md;
  } in_t;

  // Order matches the concatenation of DUT outputs sampled by the monitor.
  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, ms, mb;
  } exp_t;

  in_t cur = '0;
  initial cur.rst = 1'b1;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       reset, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdBusy;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  assign reset       = cur.rst;
  assign Rs1D        = cur.rs1d;
  assign Rs2D        = cur.rs2d;
  assign Rs1E        = cur.rs1e;
  assign Rs2E        = cur.rs2e;
  assign RdE         = cur.rde;
  assign RdM         = cur.rdm;
  assign RdW         = cur.rdw;
  assign RegWriteM   = cur.rwm;
  assign RegWriteW   = cur.rww;
  assign ResultSrcE0 = cur.ld;
  assign PCSrcE      = cur.pcsrc;
  assign MulDivE     = cur.md;

  pipe_ctrl #(.MD_LATENCY(MD_LATENCY)) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MulDivE     (MulDivE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .MdStart     (MdStart),
    .MdBusy      (MdBusy)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .StallCycles (StallCycles),
    .FlushCount  (FlushCount)
`endif
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  // st drives both StallF and StallD, which always move together.
  function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic se, input logic fd,
                              input logic fe, input logic fm, input logic ms,
                              input logic mb);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = st; e.sd = st; e.se = se;
    e.fd = fd; e.fe = fe; e.fm = fm; e.ms = ms; e.mb = mb;
    return e;
  endfunction

  // Apply one cycle of inputs just after the edge and queue its expectation.
  task automatic cyc(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    cur = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Full mul/div occupancy: start, MD_LATENCY busy cycles, DONE, then idle.
  task automatic md_seq(input string tag, input in_t v, input exp_t done_e);
    cyc({tag, "_start"}, v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0));
    for (int i = 1; i <= MD_LATENCY; i++)
      cyc($sformatf("%s_busy%0d", tag, i), v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1));
    cyc({tag, "_done"}, v, done_e);
    cyc({tag, "_idle"}, in_t'('0), ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  act;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, MdStart, MdBusy};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b se=%b fd=%b fe=%b fm=%b start=%b busy=%b, expected %b",
                 nm, act.fa, act.fb, act.sf, act.sd, act.se, act.fd, act.fe,
                 act.fm, act.ms, act.mb, e);
      end
    end
  end

  initial begin
    in_t  v;
    exp_t z;
    exp_t br_lw;
    int   k;
    z     = ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    br_lw = ex(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0);

    v = '0; v.rst = 1'b1;
    cyc("reset0", v, z);
    cyc("reset1", v, z);

    // Forwarding
    v = '0; v.rs1e = 5'd5; v.rdm = 5'd5; v.rwm = 1'b1; v.rdw = 5'd5; v.rww = 1'b1;
    cyc("fwd_mem_prio", v, ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    v.rdm = 5'd0; v.rs2e = 5'd5;
    cyc("fwd_wb", v, ex(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    v.rs1e = 5'd0; v.rdm = 5'd5;
    cyc("fwd_x0_and_b_mem", v, ex(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    v.rwm = 1'b0;
    cyc("fwd_mem_wen_off", v, ex(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));

    // Load-use
    v = '0; v.ld = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7;
    cyc("lw_stall", v, ex(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0));
    v.rde = 5'd0; v.rs2d = 5'd0;
    cyc("lw_rd_x0", v, z);
    v = '0; v.rs1d = 5'd7; v.rde = 5'd7;
    cyc("no_load", v, z);

    // Branch flush, alone and together with a load-use stall
    v = '0; v.pcsrc = 1'b1;
    cyc("branch", v, ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0));
    v.ld = 1'b1; v.rde = 5'd7; v.rs1d = 5'd7;
    cyc("branch_lw", v, br_lw);

    // Plain mul/div; MulDivE stays high through DONE
    v = '0; v.md = 1'b1;
    md_seq("md", v, z);

    // Mul/div masking load-use and branch; they reappear in DONE
    v = '0; v.md = 1'b1; v.ld = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7; v.pcsrc = 1'b1;
    md_seq("md_mask", v, br_lw);

    // Reset while BUSY with counter at 2, then a fresh full sequence
    v = '0; v.md = 1'b1;
    cyc("rb_start", v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0));
    cyc("rb_busy_cnt3", v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1));
    v.rst = 1'b1;
    cyc("rb_busy_cnt2_rst", v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1));
    v = '0;
    cyc("rb_after_reset", v, z);
    v.md = 1'b1;
    md_seq("md_restart", v, z);

`ifdef PIPE_CTRL_STATS_EN
    v = '0; v.rst = 1'b1;
    cyc("st_reset", v, z);
    v = '0; v.md = 1'b1;
    md_seq("st_md", v, z);
    v = '0; v.ld = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7;
    cyc("st_lw", v, ex(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0));
    v = '0;
    cyc("st_idle", v, z);
    checks++;
    if (StallCycles !== 32'd6) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 6", StallCycles);
    end
    checks++;
    if (FlushCount !== 32'd1) begin
      errors++;
      $display("FAIL flush_count: got %0d expected 1", FlushCount);
    end
`endif

    // Let the monitor drain every queued expectation, within a cycle budget.
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage pipelined core.
- Generates operand-forwarding selects, load-use stalls and branch flushes.
- Also sequences a shared iterative multiply/divide unit in Execute: start pulse, busy counter, and a pipeline freeze while the unit is busy.
- Sits between the datapath hazard signals and the stage pipeline registers; replaces ad-hoc stall/flush wiring.

Parameters:
- MD_LATENCY, 4: cycles the mul/div unit needs from start to valid result; legal range 2..16.
- CNT_W, $clog2(MD_LATENCY): width of the busy counter; derived, not overridden.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5 each  source registers in Decode
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute
- RdM, RdW  in  5 each  destination registers in Memory and Writeback
- RegWriteM, RegWriteW  in  1 each  write enables in Memory and Writeback
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MulDivE  in  1  Execute instruction is a mul/div op
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 Writeback result, 10 Memory ALU result
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM (insert bubble)
- MdStart  out  1  one-cycle start pulse to the mul/div unit
- MdBusy  out  1  mul/div unit in progress

Behaviour:
- Reset is synchronous and active-high. On reset: FSM goes to IDLE, counter to 0, and all registered outputs clear.
- Forwarding (combinational):
  - ForwardAE = 10 if Rs1E==RdM & RegWriteM & Rs1E!=0.
  - Else ForwardAE = 01 if Rs1E==RdW & RegWriteW & Rs1E!=0.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rules using Rs2E.
  - Memory takes priority over Writeback when both match.
- lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Mul/div FSM:
  - IDLE: if MulDivE, assert MdStart (Mealy, same cycle), load counter with MD_LATENCY-1, go to BUSY.
  - BUSY: MdBusy=1. Decrement counter each cycle. At counter==0, go to DONE.
  - DONE: one cycle. The result is valid and the Execute instruction advances. No start is accepted in DONE, so the same instruction cannot retrigger. Next state is IDLE.
- mdStall = (IDLE & MulDivE) | BUSY.
- Stage controls:
  - While mdStall: StallF = StallD = StallE = 1 and FlushM = 1, so bubbles drain into Memory.
  - StallF = StallD = lwStall | mdStall.
  - FlushE = (lwStall | PCSrcE) & !mdStall.
  - FlushD = PCSrcE & !mdStall.
  - FlushM = mdStall.
- Start-to-release latency: exactly MD_LATENCY+1 cycles of stall, then release in DONE. Total occupancy of Execute is MD_LATENCY+2 cycles including DONE.
- Simultaneous events:
  - mdStall masks lwStall and PCSrcE flushes. The held instruction in Execute is mul/div, so PCSrcE cannot legitimately be asserted.
  - PCSrcE with lwStall: FlushE=1, FlushD=1, StallF=StallD=1. The flush wins at the IF/ID register.
  - MulDivE with lwStall from Decode: the mul/div sequence runs first. The load-use check re-evaluates in DONE.
- Reset mid-BUSY: FSM goes to IDLE on the next edge. MdBusy and MdStart drop; no stale stall remains.

Optional Feature:
- Macro PIPE_CTRL_STATS_EN.
- When defined, adds ports StallCycles (out, 32) and FlushCount (out, 32).
  - StallCycles increments every cycle StallF=1.
  - FlushCount increments every cycle FlushE=1.
  - Both saturate at all-ones and clear on reset.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - md_state_t enum: IDLE, BUSY, DONE.
  - Constant REG_ZERO=5'd0.
- One sub-module, fwd_unit: a purely combinational forwarding-select block, instantiated twice (A and B operands).
- FSM, counter and stall/flush logic stay in pipe_ctrl.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01. With Rs1E=0 -> ForwardAE=00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. With RdE=0 -> no stall.
- PCSrcE=1, no other hazard -> FlushD=FlushE=1, StallF=0.
- MulDivE=1 held in Execute, MD_LATENCY=4:
  - MdStart pulses in cycle 0 only.
  - MdBusy=1 in cycles 1-4.
  - StallF/D/E and FlushM=1 in cycles 0-4.
  - Cycle 5 is DONE with all stalls 0.
  - Cycle 6 is IDLE; no second MdStart even though MulDivE was high in DONE.
- reset asserted during BUSY (counter=2) -> next edge: MdBusy=0, all stalls 0, state IDLE. A fresh MulDivE restarts the full MD_LATENCY sequence.
- PIPE_CTRL_STATS_EN defined: run the 4-cycle mul/div plus one load-use -> StallCycles=6, FlushCount=1.
